// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int DMEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF        = 32;

  typedef struct packed {
    logic pc_en;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic if_id_clear;
    logic id_ex_clear;
    logic mem_wb_clear;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: ID sources against the destination of a load in EX.
module hazard_detect (
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [4:0] rd_EX,
  input  logic       mem_read_EX,
  output logic       load_use
);

  logic hit1, hit2;

  assign hit1 = rs1_used_ID & (rs1_ID == rd_EX);
  assign hit2 = rs2_used_ID & (rs2_ID == rd_EX);

  assign load_use = mem_read_EX & (rd_EX != 5'd0) & (hit1 | hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall controller: PC enable, pipeline holds/clears,
// dmem wait timeout with sticky error, saturating perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             branch_taken_EX,
  input  logic             imem_ready,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             mem_wb_clear,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(DMEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic  load_use, freeze, in_err;
  logic  do_stall, do_flush;
  ctrl_t c;

  hazard_detect u_hazard (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .rs1_used_ID (rs1_used_ID),
    .rs2_used_ID (rs2_used_ID),
    .rd_EX       (rd_EX),
    .mem_read_EX (mem_read_EX),
    .load_use    (load_use)
  );

  assign freeze = dmem_req_MEM & ~dmem_ready;
  assign in_err = (state_q == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // wait_q counts freeze cycles already completed before this one
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN, DWAIT: begin
        if (freeze) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            state_d = DWAIT;
            wait_d  = wait_q + 1'b1;
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      ERR:     state_d = ERR;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    c = '0;
    priority case (1'b1)
      rst: begin
        c.if_id_clear  = 1'b1;
        c.id_ex_clear  = 1'b1;
        c.mem_wb_clear = 1'b1;
      end
      in_err, freeze: begin
        c.if_id_hold   = 1'b1;
        c.id_ex_hold   = 1'b1;
        c.ex_mem_hold  = 1'b1;
        c.mem_wb_clear = 1'b1;
      end
      branch_taken_EX: begin
        c.pc_en       = 1'b1;
        c.if_id_clear = 1'b1;
        c.id_ex_clear = 1'b1;
      end
      load_use: begin
        c.if_id_hold  = 1'b1;
        c.id_ex_clear = 1'b1;
      end
      !imem_ready: begin
        c.if_id_clear = 1'b1;
      end
      default: c.pc_en = 1'b1;
    endcase
  end

  assign do_stall = ~c.pc_en & ~in_err;
  assign do_flush = branch_taken_EX & ~freeze & ~in_err;

  assign stall_d = (do_stall & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  assign flush_d = (do_flush & ~&flush_q) ? flush_q + 1'b1 : flush_q;

  assign pc_en        = c.pc_en;
  assign if_id_hold   = c.if_id_hold;
  assign id_ex_hold   = c.id_ex_hold;
  assign ex_mem_hold  = c.ex_mem_hold;
  assign if_id_clear  = c.if_id_clear;
  assign id_ex_clear  = c.id_ex_clear;
  assign mem_wb_clear = c.mem_wb_clear;
  assign err          = in_err;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the RV32I 5-stage pipeline. It watches decode-stage source registers, the EX-stage load destination, the EX branch redirect and both memory handshakes. From these it generates PC enable plus hold/clear controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also enforces a data-memory wait timeout with a sticky error state, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- DMEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_ID, rs2_ID  in  5 each  source register indices of the instruction in ID.
- rs1_used_ID, rs2_used_ID  in  1 each  instruction in ID reads rs1/rs2.
- rd_EX  in  5  destination index of the instruction in EX.
- mem_read_EX  in  1  instruction in EX is a load.
- branch_taken_EX  in  1  EX resolved a taken branch or jump; PC target is valid.
- imem_ready  in  1  instruction memory returns a valid instruction this cycle.
- dmem_req_MEM  in  1  MEM stage has an active load/store.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- pc_en  out  1  PC register updates.
- if_id_hold, id_ex_hold, ex_mem_hold  out  1 each  register keeps its contents.
- if_id_clear, id_ex_clear, mem_wb_clear  out  1 each  register loads a NOP bubble.
- err  out  1  sticky data-memory timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

## Operation
- FSM states: RUN, DWAIT, ERR.
- Derived signals:
  - freeze = dmem_req_MEM & ~dmem_ready.
  - load_use = mem_read_EX & (rd_EX != 0) & ((rs1_used_ID & rs1_ID == rd_EX) | (rs2_used_ID & rs2_ID == rd_EX)).
- Controls are evaluated combinationally in the current cycle. Priority is ERR > freeze > branch > load_use > imem miss.
- **ERR:** pc_en=0; all holds=1; mem_wb_clear=1; err=1. ERR is left only by rst.
- **freeze (RUN or DWAIT):**
  - pc_en=0; if_id_hold, id_ex_hold and ex_mem_hold = 1; mem_wb_clear=1 (bubble into WB).
  - All other requests are ignored and re-evaluated after release, because the stage inputs are frozen.
- **Branch (no freeze):** pc_en=1 (PC loads target); if_id_clear=1; id_ex_clear=1. Any concurrent load_use is suppressed.
- **load_use (no freeze, no branch):** pc_en=0; if_id_hold=1; id_ex_clear=1. Exactly one bubble is inserted.
- **imem miss (!imem_ready, no higher event):** pc_en=0; if_id_clear=1. Downstream stages advance.
- **Otherwise:** pc_en=1; all holds and clears are 0.
- hold and clear are never both 1 on the same register.
- **FSM transitions:**
  - RUN→DWAIT when freeze.
  - DWAIT→RUN when dmem_ready.
  - DWAIT→ERR when the wait counter reaches DMEM_TIMEOUT-1 and freeze is still 1.
  - The wait counter clears on entry to RUN.
- **Counters:**
  - stall_cnt +1 on every non-reset cycle with pc_en=0 while not in ERR.
  - flush_cnt +1 on each branch flush.
  - Both saturate at all-ones and never wrap.

## Timing
- All outputs are combinational from inputs and state; there is zero-cycle latency from hazard to control.
- **Reset cycle (rst=1), overriding all inputs:**
  - pc_en=0; if_id_clear, id_ex_clear and mem_wb_clear = 1; holds 0.
  - Registered values at the next edge: err=0, counters=0, state=RUN, wait counter=0.
- **Reset mid-operation** (DWAIT or ERR) returns to RUN at the next edge with the same values. A pending request is dropped.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM, so load_use deasserts.
- A dmem wait of N cycles produces N cycles of freeze. The release cycle has dmem_ready=1 and all controls normal.
- Timeout: with dmem_ready held low, ERR is entered at the edge ending wait cycle DMEM_TIMEOUT.
- A branch and an imem miss in the same cycle resolve as a branch: PC loads the target and IF/ID is cleared.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN, DWAIT, ERR);
  - the NOP encoding 32'h0000_0013 used by the pipeline registers on clear;
  - the default DMEM_TIMEOUT and CNT_W values.
- One combinational sub-module, hazard_detect, computes load_use from the ID/EX fields. pipeline_ctrl contains the FSM, priority logic, wait counter and performance counters.

## Test plan
- **Load-use:** lw x5 in EX (mem_read_EX=1, rd_EX=5) with rs1_ID=5, rs1_used_ID=1 → one cycle of pc_en=0, if_id_hold=1, id_ex_clear=1; stall_cnt=1.
- **Load to x0:** rd_EX=0, rs1_ID=0 → no stall; pc_en=1.
- **Branch with load_use in the same cycle:** branch_taken_EX=1 → pc_en=1, if_id_clear=1, id_ex_clear=1, no hold; flush_cnt=1.
- **DMEM wait:** dmem_req_MEM=1, dmem_ready low for 3 cycles → 3 cycles of all holds=1 and mem_wb_clear=1; state returns to RUN; stall_cnt=3.
- **Timeout:** DMEM_TIMEOUT=4, dmem_ready never asserted → err=1 after 4 cycles; pc_en stays 0; rst=1 for one cycle → err=0, counters=0.
- **Counter saturation:** CNT_W=2, 5 consecutive imem misses → stall_cnt=3 and held there; if_id_clear=1 on every miss cycle.
